// File: rtl/uart_tx.sv
// Tick-driven UART transmitter: 8 data bits LSB first, STOP_BITS stop bits,
// with a one-byte holding register so consecutive frames run with no idle gap.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_line,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] hold, hold_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [2:0]           bit_idx, bit_idx_nxt;
  logic                 stop_cnt, stop_cnt_nxt;
  logic                 ready_nxt, line_nxt, busy_nxt, done_nxt;
  logic                 load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold     <= '0;
      shift    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      tx_ready <= 1'b1;
      tx_line  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold     <= hold_nxt;
      shift    <= shift_nxt;
      bit_idx  <= bit_idx_nxt;
      stop_cnt <= stop_cnt_nxt;
      tx_ready <= ready_nxt;
      tx_line  <= line_nxt;
      tx_busy  <= busy_nxt;
      tx_done  <= done_nxt;
    end
  end

  // tx_ready low means the holding register is full; a tick in IDLE or at the
  // end of the last stop bit then moves it straight into the shift register.
  always_comb begin
    state_nxt    = state;
    hold_nxt     = hold;
    shift_nxt    = shift;
    bit_idx_nxt  = bit_idx;
    stop_cnt_nxt = stop_cnt;
    ready_nxt    = tx_ready;
    line_nxt     = tx_line;
    busy_nxt     = tx_busy;
    done_nxt     = 1'b0;
    load         = 1'b0;

    if (tick) begin
      unique case (state)
        IDLE: begin
          if (!tx_ready) load = 1'b1;
        end
        START: begin
          line_nxt    = shift[0];
          shift_nxt   = shift >> 1;
          bit_idx_nxt = 3'd0;
          state_nxt   = DATA;
        end
        DATA: begin
          if (bit_idx == LAST_IDX) begin
            line_nxt     = 1'b1;
            stop_cnt_nxt = 1'b0;
            state_nxt    = STOP;
          end else begin
            line_nxt    = shift[0];
            shift_nxt   = shift >> 1;
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (stop_cnt != LAST_STOP) begin
            stop_cnt_nxt = stop_cnt + 1'b1;
            line_nxt     = 1'b1;
          end else begin
            done_nxt = 1'b1;
            if (!tx_ready) begin
              load = 1'b1;
            end else begin
              line_nxt  = 1'b1;
              busy_nxt  = 1'b0;
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // An accept needs an empty holding register, so it can never collide with a load.
    if (load) begin
      shift_nxt = hold;
      hold_nxt  = '0;
      ready_nxt = 1'b1;
      line_nxt  = 1'b0;
      busy_nxt  = 1'b1;
      state_nxt = START;
    end else if (tx_valid && tx_ready) begin
      hold_nxt  = tx_data;
      ready_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: decodes frames off tx_line and checks levels,
// bit timing, busy/done/ready behaviour, backpressure, reset abort and 2 stop bits.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick = 1'b0;
  logic       tx_valid, tx_valid2;
  logic [7:0] tx_data, tx_data2;
  logic       tx_ready, tx_line, tx_busy, tx_done;
  logic       tx_ready2, tx_line2, tx_busy2, tx_done2;

  int tp = 16;
  int tick_cnt = 0;
  int n_vec = 0;
  int n_err = 0;

  logic [7:0] lb_bytes [4] = '{8'h00, 8'hFF, 8'h81, 8'h3C};

  uart_tx u_dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_line(tx_line), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx #(.STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .tx_valid(tx_valid2), .tx_data(tx_data2),
    .tx_ready(tx_ready2), .tx_line(tx_line2), .tx_busy(tx_busy2), .tx_done(tx_done2)
  );

  always #5 clk = ~clk;

  // Baud tick: one clk cycle high every tp cycles, changed on the falling edge.
  initial forever begin
    @(negedge clk);
    if (tick_cnt >= tp - 1) begin
      tick = 1'b1;
      tick_cnt = 0;
    end else begin
      tick = 1'b0;
      tick_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic line_of(input int sel);
    return (sel != 0) ? tx_line2 : tx_line;
  endfunction
  function automatic logic ready_of(input int sel);
    return (sel != 0) ? tx_ready2 : tx_ready;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel != 0) ? tx_busy2 : tx_busy;
  endfunction
  function automatic logic done_of(input int sel);
    return (sel != 0) ? tx_done2 : tx_done;
  endfunction

  task automatic send(input int sel, input logic [7:0] b, input string tag);
    int w;
    w = 0;
    while (ready_of(sel) !== 1'b1 && w < 4096) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_rdy"}, 32'(w < 4096), 32'd1);
    if (sel != 0) begin
      tx_data2 = b; tx_valid2 = 1'b1;
    end else begin
      tx_data = b; tx_valid = 1'b1;
    end
    @(negedge clk);
    if (sel != 0) tx_valid2 = 1'b0;
    else tx_valid = 1'b0;
    chk({tag, "_acc"}, 32'(ready_of(sel)), 32'd0);
  endtask

  task automatic expect_frame(input int sel, input logic [7:0] b, input int nstop,
                              input logic more, input string tag, output int gap);
    int         slots, unstable, busy_lo, early_done, w;
    logic [10:0] lvl;
    logic        stop_ok;
    slots = 9 + nstop;
    lvl = '0; unstable = 0; busy_lo = 0; early_done = 0; w = 0;
    while (line_of(sel) !== 1'b0 && w < 64 * tp + 64) begin
      @(negedge clk);
      w++;
    end
    gap = w;
    chk({tag, "_start"}, 32'(line_of(sel) === 1'b0), 32'd1);
    if (line_of(sel) !== 1'b0) return;
    for (int s = 0; s < slots; s++) begin
      for (int c = 0; c < tp; c++) begin
        if (s != 0 || c != 0) begin
          @(negedge clk);
          if (done_of(sel) !== 1'b0) early_done++;
        end
        if (c == 0) lvl[s] = line_of(sel);
        else if (line_of(sel) !== lvl[s]) unstable++;
        if (busy_of(sel) !== 1'b1) busy_lo++;
      end
    end
    @(negedge clk);
    stop_ok = 1'b1;
    for (int s = 9; s < slots; s++) if (lvl[s] !== 1'b1) stop_ok = 1'b0;
    chk({tag, "_data"}, 32'(lvl[8:1]), 32'(b));
    chk({tag, "_stop"}, 32'(stop_ok), 32'd1);
    chk({tag, "_width"}, 32'(unstable), 32'd0);
    chk({tag, "_busy"}, 32'(busy_lo), 32'd0);
    chk({tag, "_done_early"}, 32'(early_done), 32'd0);
    chk({tag, "_done"}, 32'(done_of(sel)), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy_of(sel)), 32'(more));
    chk({tag, "_line_after"}, 32'(line_of(sel)), more ? 32'd0 : 32'd1);
  endtask

  initial begin
    int g, w, cnt_done, cnt_low, cnt_nrdy;
    rst_n = 1'b0;
    tx_valid = 1'b0; tx_valid2 = 1'b0;
    tx_data = 8'h00; tx_data2 = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_line", 32'(tx_line), 32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte, 16 clk per bit
    tp = 16;
    send(0, 8'hA5, "a5");
    expect_frame(0, 8'hA5, 1, 1'b0, "a5", g);
    @(negedge clk);
    chk("a5_done_once", 32'(tx_done), 32'd0);

    // Back-to-back with tx_valid held high for the second byte
    send(0, 8'h55, "b2b0");
    tx_data = 8'h0F;
    tx_valid = 1'b1;
    fork
      begin
        expect_frame(0, 8'h55, 1, 1'b1, "b2b0", g);
        expect_frame(0, 8'h0F, 1, 1'b0, "b2b1", g);
        chk("b2b_gap", 32'(g), 32'd0);
      end
      begin
        w = 0;
        while (tx_ready !== 1'b1 && w < 4096) begin
          @(negedge clk);
          w++;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        chk("b2b_acc", 32'(tx_ready), 32'd0);
      end
    join

    // Backpressure: a pulse while the holding register is full is ignored
    send(0, 8'h81, "bp0");
    fork
      begin
        expect_frame(0, 8'h81, 1, 1'b1, "bp0", g);
        expect_frame(0, 8'h42, 1, 1'b0, "bp1", g);
      end
      begin
        send(0, 8'h42, "bp1");
        repeat (3) @(negedge clk);
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("bp_ignored", 32'(tx_ready), 32'd0);
      end
    join

    // Decoded-frame loopback at 4 clk per bit, then a tick on every cycle
    tp = 4;
    for (int i = 0; i < 4; i++) begin
      send(0, lb_bytes[i], $sformatf("lb4_%0d", i));
      expect_frame(0, lb_bytes[i], 1, 1'b0, $sformatf("lb4_%0d", i), g);
    end
    tp = 1;
    for (int i = 0; i < 4; i++) begin
      send(0, lb_bytes[i], $sformatf("lb1_%0d", i));
      expect_frame(0, lb_bytes[i], 1, 1'b0, $sformatf("lb1_%0d", i), g);
    end

    // Reset during DATA bit 3 of 0xC3 with 0x99 pending
    tp = 8;
    repeat (20) @(negedge clk);
    send(0, 8'hC3, "rs0");
    send(0, 8'h99, "rs1");
    repeat (35) @(negedge clk);
    chk("rs_pre_line", 32'(tx_line), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rs_line", 32'(tx_line), 32'd1);
    chk("rs_ready", 32'(tx_ready), 32'd1);
    chk("rs_busy", 32'(tx_busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt_done = 0; cnt_low = 0; cnt_nrdy = 0;
    repeat (20 * 8) begin
      @(negedge clk);
      if (tx_done !== 1'b0) cnt_done++;
      if (tx_line !== 1'b1) cnt_low++;
      if (tx_ready !== 1'b1) cnt_nrdy++;
    end
    chk("rs_no_done", 32'(cnt_done), 32'd0);
    chk("rs_idle_line", 32'(cnt_low), 32'd0);
    chk("rs_ready_after", 32'(cnt_nrdy), 32'd0);

    // Two stop bits on the second instance
    tp = 16;
    send(1, 8'h12, "s2");
    expect_frame(1, 8'h12, 2, 1'b0, "s2", g);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
